// File: rtl/axi_lite_master_port_if.sv
// Request/response port from the cache controller plus the AXI4-Lite channels.
// The master modport is the block's own view; the slave modport is the opposite side.
interface axi_lite_master_port_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
      input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid,
      output req_ready, rsp_valid, rsp_rdata, rsp_resp,
      output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
      output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid,
      input  req_ready, rsp_valid, rsp_rdata, rsp_resp,
      input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready
   );
endinterface

// File: rtl/axi_lite_master_port.sv
// Single-outstanding AXI4-Lite master bridging a simple request/response port.
// Optional watchdog with late-response drain: define AXIL_MASTER_TIMEOUT_EN.
module axi_lite_master_port #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic                    aclk,
   input logic                    areset,
   axi_lite_master_port_if.master bus
);

   typedef enum logic [2:0] {
      IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP
`ifdef AXIL_MASTER_TIMEOUT_EN
      , DRAIN
`endif
   } state_t;

   state_t      state_q;
   logic        req_ready_q, rsp_valid_q;
   logic [31:0] rsp_rdata_q;
   logic [1:0]  rsp_resp_q;
   logic [31:0] araddr_q, awaddr_q, wdata_q;
   logic [3:0]  wstrb_q;
   logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
   logic        aw_done_q, w_done_q, wr_pend_q;

   logic ar_fire, r_fire, aw_fire, w_fire, b_fire, aw_w_done;

   assign ar_fire   = arvalid_q & bus.arready;
   assign r_fire    = rready_q  & bus.rvalid;
   assign aw_fire   = awvalid_q & bus.awready;
   assign w_fire    = wvalid_q  & bus.wready;
   assign b_fire    = bready_q  & bus.bvalid;
   // Both write halves complete, counting a handshake that fires this cycle
   assign aw_w_done = wr_pend_q & (aw_done_q | aw_fire) & (w_done_q | w_fire);

`ifdef AXIL_MASTER_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES < 256) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q;
   logic             timeout_q;
   logic             busy, expired, pending;

   assign busy    = (state_q == RD_ADDR) || (state_q == RD_DATA) ||
                    (state_q == WR_REQ)  || (state_q == WR_RESP);
   assign expired = busy && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !r_fire && !b_fire;
   assign pending = arvalid_q | rready_q | awvalid_q | wvalid_q | bready_q | wr_pend_q;
`endif

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
         araddr_q    <= '0;
         awaddr_q    <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         wr_pend_q   <= 1'b0;
`ifdef AXIL_MASTER_TIMEOUT_EN
         cnt_q       <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         // Channel handshakes progress in every state so a drain can finish them
         if (ar_fire) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
         end
         if (r_fire)  rready_q  <= 1'b0;
         if (aw_fire) awvalid_q <= 1'b0;
         if (w_fire)  wvalid_q  <= 1'b0;
         if (aw_w_done) begin
            bready_q  <= 1'b1;
            wr_pend_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
         end else begin
            if (aw_fire) aw_done_q <= 1'b1;
            if (w_fire)  w_done_q  <= 1'b1;
         end
         if (b_fire) bready_q <= 1'b0;
`ifdef AXIL_MASTER_TIMEOUT_EN
         if (busy) cnt_q <= cnt_q + 1'b1;
`endif

         case (state_q)
            IDLE: begin
               if (bus.req_valid && req_ready_q) begin
                  req_ready_q <= 1'b0;
`ifdef AXIL_MASTER_TIMEOUT_EN
                  cnt_q       <= '0;
`endif
                  if (bus.req_write) begin
                     awaddr_q  <= bus.req_addr;
                     wdata_q   <= bus.req_wdata;
                     wstrb_q   <= bus.req_wstrb;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     wr_pend_q <= 1'b1;
                     state_q   <= WR_REQ;
                  end else begin
                     araddr_q  <= bus.req_addr;
                     arvalid_q <= 1'b1;
                     state_q   <= RD_ADDR;
                  end
               end
            end
            RD_ADDR: if (ar_fire) state_q <= RD_DATA;
            RD_DATA: begin
               if (r_fire) begin
                  rsp_rdata_q <= bus.rdata;
                  rsp_resp_q  <= bus.rresp;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RSP;
               end
            end
            WR_REQ: if (aw_w_done) state_q <= WR_RESP;
            WR_RESP: begin
               if (b_fire) begin
                  rsp_rdata_q <= '0;
                  rsp_resp_q  <= bus.bresp;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RSP;
               end
            end
            RSP: begin
               if (rsp_valid_q && bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
`ifdef AXIL_MASTER_TIMEOUT_EN
                  if (timeout_q) begin
                     timeout_q <= 1'b0;
                     state_q   <= DRAIN;
                  end else begin
                     req_ready_q <= 1'b1;
                     state_q     <= IDLE;
                  end
`else
                  req_ready_q <= 1'b1;
                  state_q     <= IDLE;
`endif
               end
            end
`ifdef AXIL_MASTER_TIMEOUT_EN
            DRAIN: begin
               if (!pending) begin
                  req_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
`endif
            default: state_q <= IDLE;
         endcase

`ifdef AXIL_MASTER_TIMEOUT_EN
         // Watchdog overrides the wait; outstanding channels are left to drain
         if (expired) begin
            rsp_valid_q <= 1'b1;
            rsp_resp_q  <= 2'b11;
            rsp_rdata_q <= '0;
            timeout_q   <= 1'b1;
            state_q     <= RSP;
         end
`endif
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_resp  = rsp_resp_q;
   assign bus.araddr    = araddr_q;
   assign bus.arvalid   = arvalid_q;
   assign bus.rready    = rready_q;
   assign bus.awaddr    = awaddr_q;
   assign bus.awvalid   = awvalid_q;
   assign bus.wdata     = wdata_q;
   assign bus.wstrb     = wstrb_q;
   assign bus.wvalid    = wvalid_q;
   assign bus.bready    = bready_q;

endmodule

// File: tb/tb_axi_lite_master_port.sv
// Directed bench for axi_lite_master_port: reset, read/write paths, error passthrough,
// response backpressure, reset mid-transaction and (when compiled in) the watchdog.
module tb_axi_lite_master_port;

`ifdef AXIL_MASTER_TIMEOUT_EN
   localparam int unsigned TO = 16;
`else
   localparam int unsigned TO = 255;
`endif

   logic aclk = 1'b0;
   logic areset = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   axi_lite_master_port_if bus ();

   axi_lite_master_port #(.TIMEOUT_CYCLES(TO)) dut (
      .aclk   (aclk),
      .areset (areset),
      .bus    (bus.master)
   );

   always #5 aclk = ~aclk;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.req_valid = 0; bus.req_write = 0; bus.req_addr = '0; bus.req_wdata = '0;
      bus.req_wstrb = '0; bus.rsp_ready = 0; bus.arready = 0; bus.rdata = '0;
      bus.rresp = '0; bus.rvalid = 0; bus.awready = 0; bus.wready = 0;
      bus.bresp = '0; bus.bvalid = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      areset = 1;
      tick(); tick();
      n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %0h exp 1", bus.req_ready); end
      n_checks++; if ({bus.rsp_valid, bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready} !== 6'b0) begin n_fail++;
         $display("FAIL rst_valids: got %06b exp 000000", {bus.rsp_valid, bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready}); end
      n_checks++; if ({bus.araddr, bus.awaddr, bus.wdata, bus.wstrb, bus.rsp_rdata, bus.rsp_resp} !== '0) begin n_fail++;
         $display("FAIL rst_data: araddr %0h awaddr %0h wdata %0h wstrb %0h rdata %0h resp %0h exp all 0",
                  bus.araddr, bus.awaddr, bus.wdata, bus.wstrb, bus.rsp_rdata, bus.rsp_resp); end
      areset = 0;
      tick();
      n_checks++; if (bus.req_ready !== 1'b1 || bus.arvalid !== 1'b0) begin n_fail++;
         $display("FAIL rst_release: req_ready %0h arvalid %0h exp 1/0", bus.req_ready, bus.arvalid); end
   endtask

   task automatic test_read_basic();
      bus.arready = 1; bus.rvalid = 1; bus.rdata = 32'hCAFE_F00D; bus.rresp = 2'b00;
      bus.req_valid = 1; bus.req_write = 0; bus.req_addr = 32'h0000_0014;
      tick(); // acceptance edge N
      bus.req_valid = 0;
      n_checks++; if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h14 || bus.req_ready !== 1'b0) begin n_fail++;
         $display("FAIL rd_ar: arvalid %0h araddr %0h req_ready %0h exp 1/14/0", bus.arvalid, bus.araddr, bus.req_ready); end
      tick(); // N+1
      n_checks++; if (bus.arvalid !== 1'b0 || bus.rready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_fail++;
         $display("FAIL rd_rready: arvalid %0h rready %0h rsp_valid %0h exp 0/1/0", bus.arvalid, bus.rready, bus.rsp_valid); end
      tick(); // N+2
      bus.rvalid = 0;
      n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rready !== 1'b0) begin n_fail++;
         $display("FAIL rd_latency: rsp_valid %0h rready %0h exp 1/0", bus.rsp_valid, bus.rready); end
      n_checks++; if (bus.rsp_rdata !== 32'hCAFE_F00D || bus.rsp_resp !== 2'b00) begin n_fail++;
         $display("FAIL rd_data: rdata %0h resp %0h exp cafef00d/0", bus.rsp_rdata, bus.rsp_resp); end
      bus.rsp_ready = 1;
      tick();
      bus.rsp_ready = 0; bus.arready = 0;
      n_checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++;
         $display("FAIL rd_done: rsp_valid %0h req_ready %0h exp 0/1", bus.rsp_valid, bus.req_ready); end
   endtask

   task automatic test_write_w_first();
      int b_count;
      b_count = 0;
      bus.req_valid = 1; bus.req_write = 1; bus.req_addr = 32'h0000_0020;
      bus.req_wdata = 32'h1234_5678; bus.req_wstrb = 4'b0011;
      tick(); // N
      bus.req_valid = 0; bus.req_wdata = '0; bus.req_wstrb = '0;
      bus.wready = 1;
      n_checks++; if (bus.awvalid !== 1'b1 || bus.wvalid !== 1'b1 || bus.awaddr !== 32'h20) begin n_fail++;
         $display("FAIL wr_valids: awvalid %0h wvalid %0h awaddr %0h exp 1/1/20", bus.awvalid, bus.wvalid, bus.awaddr); end
      n_checks++; if (bus.wdata !== 32'h1234_5678 || bus.wstrb !== 4'b0011) begin n_fail++;
         $display("FAIL wr_wdata: wdata %0h wstrb %0h exp 12345678/3", bus.wdata, bus.wstrb); end
      tick(); // W handshake at N+1
      bus.wready = 0;
      n_checks++; if (bus.wvalid !== 1'b0 || bus.awvalid !== 1'b1 || bus.bready !== 1'b0) begin n_fail++;
         $display("FAIL wr_w_only: wvalid %0h awvalid %0h bready %0h exp 0/1/0", bus.wvalid, bus.awvalid, bus.bready); end
      tick(); tick();
      n_checks++; if (bus.awvalid !== 1'b1 || bus.awaddr !== 32'h20 || bus.bready !== 1'b0) begin n_fail++;
         $display("FAIL wr_aw_hold: awvalid %0h awaddr %0h bready %0h exp 1/20/0", bus.awvalid, bus.awaddr, bus.bready); end
      bus.awready = 1;
      tick(); // AW handshake, W already done
      bus.awready = 0; bus.bvalid = 1; bus.bresp = 2'b00;
      n_checks++; if (bus.awvalid !== 1'b0 || bus.bready !== 1'b1) begin n_fail++;
         $display("FAIL wr_bready: awvalid %0h bready %0h exp 0/1", bus.awvalid, bus.bready); end
      for (int i = 0; i < 4; i++) begin
         if (bus.bready && bus.bvalid) b_count++;
         tick();
      end
      bus.bvalid = 0;
      n_checks++; if (b_count !== 1) begin n_fail++; $display("FAIL wr_b_count: got %0d exp 1", b_count); end
      n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_resp !== 2'b00 || bus.rsp_rdata !== 32'h0) begin n_fail++;
         $display("FAIL wr_rsp: rsp_valid %0h resp %0h rdata %0h exp 1/0/0", bus.rsp_valid, bus.rsp_resp, bus.rsp_rdata); end
      bus.rsp_ready = 1;
      tick();
      bus.rsp_ready = 0;
      n_checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_fail++;
         $display("FAIL wr_done: req_ready %0h rsp_valid %0h exp 1/0", bus.req_ready, bus.rsp_valid); end
   endtask

   task automatic test_slverr_backpressure();
      bus.arready = 1; bus.rvalid = 1; bus.rdata = 32'hDEAD_BEEF; bus.rresp = 2'b10;
      bus.req_valid = 1; bus.req_write = 0; bus.req_addr = 32'h0000_0200;
      tick(); tick(); tick(); // rsp_valid after N+2
      n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_resp !== 2'b10 || bus.rsp_rdata !== 32'hDEAD_BEEF) begin n_fail++;
         $display("FAIL err_rsp: rsp_valid %0h resp %0h rdata %0h exp 1/2/deadbeef", bus.rsp_valid, bus.rsp_resp, bus.rsp_rdata); end
      bus.rdata = 32'h0BAD_0BAD; bus.rresp = 2'b00;
      bus.req_addr = 32'h0000_0300;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDEAD_BEEF || bus.rsp_resp !== 2'b10) begin n_fail++;
            $display("FAIL bp_hold[%0d]: rsp_valid %0h rdata %0h resp %0h exp 1/deadbeef/2", i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_resp); end
         n_checks++; if (bus.req_ready !== 1'b0 || bus.arvalid !== 1'b0) begin n_fail++;
            $display("FAIL bp_no_req[%0d]: req_ready %0h arvalid %0h exp 0/0", i, bus.req_ready, bus.arvalid); end
      end
      bus.req_valid = 0; bus.rsp_ready = 1;
      tick();
      bus.rsp_ready = 0; bus.rvalid = 0; bus.arready = 0;
      n_checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.arvalid !== 1'b0) begin n_fail++;
         $display("FAIL bp_release: rsp_valid %0h req_ready %0h arvalid %0h exp 0/1/0", bus.rsp_valid, bus.req_ready, bus.arvalid); end
   endtask

   task automatic test_back_to_back();
      bus.awready = 1; bus.wready = 1; bus.bvalid = 1; bus.bresp = 2'b00;
      bus.arready = 1; bus.rvalid = 1; bus.rdata = 32'h1111_2222; bus.rresp = 2'b00;
      bus.rsp_ready = 1;
      bus.req_valid = 1; bus.req_write = 1; bus.req_addr = 32'h0000_0030;
      bus.req_wdata = 32'hA5A5_5A5A; bus.req_wstrb = 4'b1111;
      tick(); // write accepted at M-3
      bus.req_write = 0; bus.req_addr = 32'h0000_0040;
      tick();
      n_checks++; if (bus.bready !== 1'b1 || bus.awvalid !== 1'b0 || bus.wvalid !== 1'b0) begin n_fail++;
         $display("FAIL b2b_aw_w: bready %0h awvalid %0h wvalid %0h exp 1/0/0", bus.bready, bus.awvalid, bus.wvalid); end
      tick();
      n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_resp !== 2'b00 || bus.req_ready !== 1'b0) begin n_fail++;
         $display("FAIL b2b_wr_rsp: rsp_valid %0h resp %0h req_ready %0h exp 1/0/0", bus.rsp_valid, bus.rsp_resp, bus.req_ready); end
      tick(); // response handshake at M
      n_checks++; if (bus.req_ready !== 1'b1 || bus.arvalid !== 1'b0) begin n_fail++;
         $display("FAIL b2b_ready: req_ready %0h arvalid %0h exp 1/0", bus.req_ready, bus.arvalid); end
      tick(); // read accepted
      bus.req_valid = 0; bus.bvalid = 0;
      n_checks++; if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h40 || bus.req_ready !== 1'b0) begin n_fail++;
         $display("FAIL b2b_rd_acc: arvalid %0h araddr %0h req_ready %0h exp 1/40/0", bus.arvalid, bus.araddr, bus.req_ready); end
      tick(); tick();
      n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h1111_2222) begin n_fail++;
         $display("FAIL b2b_rd_rsp: rsp_valid %0h rdata %0h exp 1/11112222", bus.rsp_valid, bus.rsp_rdata); end
      tick();
      idle_inputs();
      n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_end: req_ready %0h exp 1", bus.req_ready); end
   endtask

   task automatic test_reset_mid();
      bus.req_valid = 1; bus.req_write = 0; bus.req_addr = 32'h0000_0050;
      tick();
      bus.req_valid = 0;
      tick();
      n_checks++; if (bus.arvalid !== 1'b1) begin n_fail++; $display("FAIL mid_pre: arvalid %0h exp 1", bus.arvalid); end
      areset = 1;
      tick();
      areset = 0;
      n_checks++; if (bus.arvalid !== 1'b0 || bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_fail++;
         $display("FAIL mid_reset: arvalid %0h req_ready %0h rsp_valid %0h exp 0/1/0", bus.arvalid, bus.req_ready, bus.rsp_valid); end
      tick();
   endtask

`ifdef AXIL_MASTER_TIMEOUT_EN
   task automatic test_timeout();
      int waited;
      bus.arready = 0; bus.rvalid = 0; bus.rdata = 32'h7777_7777; bus.rresp = 2'b00;
      bus.req_valid = 1; bus.req_write = 0; bus.req_addr = 32'h0000_0060;
      tick(); // acceptance edge N
      bus.req_valid = 0;
      for (int i = 0; i < 15; i++) tick();
      n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL to_early: rsp_valid %0h exp 0", bus.rsp_valid); end
      tick(); // N+16
      n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_resp !== 2'b11 || bus.rsp_rdata !== 32'h0 || bus.arvalid !== 1'b1) begin n_fail++;
         $display("FAIL to_rsp: rsp_valid %0h resp %0h rdata %0h arvalid %0h exp 1/3/0/1", bus.rsp_valid, bus.rsp_resp, bus.rsp_rdata, bus.arvalid); end
      bus.rsp_ready = 1;
      tick();
      bus.rsp_ready = 0;
      for (int i = 0; i < 22; i++) begin
         n_checks++; if (bus.req_ready !== 1'b0 || bus.arvalid !== 1'b1) begin n_fail++;
            $display("FAIL to_drain[%0d]: req_ready %0h arvalid %0h exp 0/1", i, bus.req_ready, bus.arvalid); end
         tick();
      end
      bus.arready = 1; bus.rvalid = 1;
      tick();
      bus.arready = 0;
      n_checks++; if (bus.rready !== 1'b1 || bus.req_ready !== 1'b0) begin n_fail++;
         $display("FAIL to_rready: rready %0h req_ready %0h exp 1/0", bus.rready, bus.req_ready); end
      tick();
      bus.rvalid = 0;
      waited = 0;
      while (bus.req_ready !== 1'b1 && waited < 10) begin tick(); waited++; end
      n_checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_fail++;
         $display("FAIL to_idle: req_ready %0h rsp_valid %0h exp 1/0 within 10 cycles", bus.req_ready, bus.rsp_valid); end
   endtask
`endif

   initial begin
      test_reset();
      test_read_basic();
      test_write_w_first();
      test_slverr_backpressure();
      test_back_to_back();
      test_reset_mid();
`ifdef AXIL_MASTER_TIMEOUT_EN
      test_timeout();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_lite_master_port.md
# axi_lite_master_port

Single-outstanding AXI4-Lite master that converts a simple request/response port from the cache controller into AXI4-Lite read and write transactions toward the AXI-Lite slave memory. One transaction is in flight at a time. Address, data and strobe are captured at request acceptance, driven on the AXI channels, and the read data or error status is returned on the response port.

## Interface
- TIMEOUT_CYCLES, 255: watchdog limit in cycles; used only when the timeout feature is compiled in.
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request; high only in IDLE.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- req_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  read data. Zero for writes.
- rsp_resp  out  2  AXI response code: 00 OKAY, 10 SLVERR, 11 timeout.
- araddr/arvalid out 32/1, arready in 1; rdata in 32, rresp in 2, rvalid in 1, rready out 1.
- awaddr/awvalid out 32/1, awready in 1; wdata out 32, wstrb out 4, wvalid out 1, wready in 1.
- bresp in 2, bvalid in 1, bready out 1.

## Operation
- All outputs are registered.
- Reset values:
  - all valid and ready outputs are 0, except req_ready = 1.
  - araddr, awaddr, wdata, wstrb, rsp_rdata and rsp_resp are 0.
  - state is IDLE.
- The FSM has seven states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP and DRAIN.
- IDLE:
  - On req_valid && req_ready, capture the request.
  - For a read, load araddr, set arvalid and go to RD_ADDR.
  - For a write, load awaddr, wdata and wstrb, set both awvalid and wvalid, and go to WR_REQ.
- RD_ADDR:
  - On arvalid && arready, clear arvalid, set rready and go to RD_DATA.
- RD_DATA:
  - On rvalid && rready, latch rdata into rsp_rdata and rresp into rsp_resp.
  - Clear rready, set rsp_valid and go to RSP.
- WR_REQ:
  - The AW and W handshakes complete independently, in any order or in the same cycle. Each valid clears on its own handshake.
  - Sticky flags aw_done and w_done track completion.
  - When both flags are set (including the cycle in which the last handshake fires), set bready and go to WR_RESP.
- WR_RESP:
  - On bvalid && bready, set rsp_resp = bresp and rsp_rdata = 0.
  - Clear bready, set rsp_valid and go to RSP.
- RSP:
  - rsp_valid, rsp_rdata and rsp_resp hold stable until rsp_ready.
  - On rsp_valid && rsp_ready, clear rsp_valid, set req_ready and go to IDLE.
- Valids are never withdrawn before their handshake completes. AXI outputs hold stable while valid is high.
- AXI rresp and bresp values are passed through unmodified; the block does not interpret address ranges.

## Timing
- A request accepted at edge N drives arvalid or awvalid/wvalid from cycle N+1.
- Minimum read latency, with arready and rvalid both already high:
  - AR handshake in cycle N+1.
  - rready high in cycle N+2, R handshake in N+2.
  - rsp_valid high in cycle N+3.
- Minimum write latency, with AW and W accepted in N+1 and bvalid high: B handshake in N+2, rsp_valid high in N+3.
- Back-to-back: after the response handshake at edge M, req_ready is high in cycle M+1, so there is at most one request per 4 cycles.
- Reset mid-transaction returns to IDLE on the next edge and drops all valids. In-flight AXI state is abandoned; the slave must be reset together with this block.

## Configuration
- AXIL_MASTER_TIMEOUT_EN, when defined:
  - An 8+ bit counter clears on entry to RD_ADDR or WR_REQ and increments every cycle in RD_ADDR, RD_DATA, WR_REQ and WR_RESP.
  - When the count reaches TIMEOUT_CYCLES, the block returns rsp_resp = 11 with rsp_rdata = 0 and enters RSP, then DRAIN after the response handshake instead of IDLE.
  - DRAIN: keeps the pending valids asserted and holds rready or bready high until the outstanding AXI transaction completes. The late response is discarded, then the block goes to IDLE. req_ready stays 0 during DRAIN.
- When undefined: there is no counter and no DRAIN state, and the block waits indefinitely.

## Test plan
- Read 0x0000_0014, slave returns rdata = 0xCAFE_F00D, rresp = 00 -> rsp_rdata = 0xCAFE_F00D, rsp_resp = 00; rsp_valid exactly 3 cycles after acceptance with zero-wait slave.
- Write 0x0000_0020, wdata = 0x1234_5678, wstrb = 0011; slave asserts wready 3 cycles before awready -> a single B handshake; rsp_resp = 00; wdata and wstrb stable until the W handshake.
- Read 0x0000_0200, slave returns rdata = 0xDEAD_BEEF, rresp = 10 -> rsp_resp = 10 and rsp_rdata = 0xDEAD_BEEF.
- Response backpressure: rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata held constant, req_ready low throughout, and no new arvalid.
- areset asserted while arvalid = 1 in RD_ADDR -> the next cycle has arvalid = 0, req_ready = 1 and rsp_valid = 0.
- With AXIL_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES = 16, and the slave holding arready low for 40 cycles:
  - rsp_resp = 11 after 16 cycles.
  - After the response handshake, req_ready stays 0 until the late R handshake completes, then returns to 1.
